register_file: RTL
==================

// Module: register_file
// PURPOSE
//  Parametrised successor to the 8x16 one-hot-enable register bank: a DEPTH x WIDTH
//  register file with one write port and two registered read ports.
//  Writes use a binary address; reads are write-first bypassed.
//  A clear sequencer zeroes all entries. A flat snapshot bus replaces the per-register q outputs.
//  Sits between the writeback path (dest register) and the operand fetch stage.
// PARAMETERS
//  WIDTH  16  data width of each register, >= 1
//  DEPTH  8   number of registers, 2..2**AW
//  AW     3   address width; addresses >= DEPTH are out of range
// PORTS
//  clk        in   1           rising-edge clock; the only clock
//  rst        in   1           synchronous, active-high reset
//  we         in   1           write request this cycle
//  waddr      in   AW          write address
//  wdata      in   WIDTH       write data
//  raddr_a    in   AW          read port A address
//  raddr_b    in   AW          read port B address
//  rdata_a    out  WIDTH       read port A data, registered
//  rdata_b    out  WIDTH       read port B data, registered
//  clr_start  in   1           start clear-all sequence (level sampled in IDLE)
//  busy       out  1           clear sequence in progress
//  wr_err     out  1           1-cycle pulse: previous cycle's write was dropped
//  regs_flat  out  WIDTH*DEPTH reg i on [i*WIDTH +: WIDTH], combinational from storage
// BEHAVIOUR
//  Reset:
//   - All registers 0; rdata_a/b 0; busy 0; wr_err 0.
//   - State IDLE, clear pointer 0.
//   - rst overrides all other inputs, including mid-clear (clear is abandoned).
//  Write:
//   - Accepted at a clk edge when we=1, waddr<DEPTH and state=IDLE.
//   - Effect: reg[waddr]<=wdata.
//   - When we=1 and (waddr>=DEPTH or state=CLEAR), the write is dropped and wr_err=1 next cycle.
//   - Otherwise wr_err=0.
//  Read: 1-cycle latency. At each edge, rdata_x <=
//   - 0 if raddr_x>=DEPTH; otherwise
//   - wdata if a write to raddr_x is accepted this edge (write-first bypass); otherwise
//   - 0 if the clear writes raddr_x this edge; otherwise
//   - reg[raddr_x].
//   - Ports A and B are independent; both may read the same address.
//  Clear FSM (states IDLE, CLEAR):
//   - IDLE -> CLEAR at an edge with clr_start=1; ptr<=0.
//     A write accepted at that same edge still takes effect.
//   - CLEAR: each edge, reg[ptr]<=0 and ptr<=ptr+1.
//     At ptr==DEPTH-1, return to IDLE and set ptr<=0.
//   - busy = (state==CLEAR), registered: high exactly DEPTH cycles.
//     It starts the cycle after clr_start is sampled.
//   - clr_start is ignored while busy; holding it high after return restarts the clear.
//  Widths: ptr is AW bits and never exceeds DEPTH-1; no arithmetic on data.
// TESTING
//  1. rst 2 cycles; then we=1 waddr=0 wdata=0, then waddr=1 wdata=1 (legacy bank
//     sequence); raddr_a=0, raddr_b=1 -> rdata_a=0, rdata_b=1 one cycle later;
//     regs_flat[31:16]=1.
//  2. Bypass: we=1 waddr=3 wdata=16'hBEEF with raddr_a=3 in the same cycle
//     -> rdata_a=16'hBEEF the next cycle.
//  3. Clear: fill r0..r7 with 16'h1111*i; pulse clr_start
//     -> busy high exactly 8 cycles; then all regs_flat=0 and rdata reads 0.
//  4. Write during busy: we=1 waddr=2 wdata=16'h00AA at the 3rd busy cycle
//     -> reg2 stays 0; wr_err=1 for exactly 1 cycle.
//  5. DEPTH=6 instance: write waddr=6 -> dropped, wr_err pulse;
//     read raddr_b=7 -> rdata_b=0.
//  6. Reset mid-clear: rst at 4th busy cycle -> next cycle busy=0, all regs 0;
//     a subsequent write to r5 is accepted normally.

Source files
------------

// File: rtl/register_file_if.sv
// Bus between the writeback/operand-fetch stages and the register file.
// Carries write, dual read, clear-control and snapshot signals.
interface register_file_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
);
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic [AW-1:0]          raddr_a;
  logic [AW-1:0]          raddr_b;
  logic [WIDTH-1:0]       rdata_a;
  logic [WIDTH-1:0]       rdata_b;
  logic                   clr_start;
  logic                   busy;
  logic                   wr_err;
  logic [WIDTH*DEPTH-1:0] regs_flat;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, clr_start,
    input  rdata_a, rdata_b, busy, wr_err, regs_flat
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, clr_start,
    output rdata_a, rdata_b, busy, wr_err, regs_flat
  );
endinterface

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: one write port, two registered write-first read
// ports, a sequential clear-all engine and a flat snapshot of every entry.
module register_file #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state, next_state;
  logic [AW-1:0]    ptr, next_ptr;
  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] next_a, next_b;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {{(32-AW){1'b0}}, a} < 32'(DEPTH);
  endfunction

  assign wr_ok    = bus.we && in_range(bus.waddr) && (state == IDLE);
  assign bus.busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      IDLE: begin
        if (bus.clr_start) begin
          next_state = CLEAR;
          next_ptr   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          next_state = IDLE;
          next_ptr   = '0;
        end else begin
          next_ptr = ptr + AW'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_ptr   = '0;
      end
    endcase
  end

  // Priority, lowest first: stored value, clear of this entry, write bypass, range check.
  always_comb begin
    next_a = regs[bus.raddr_a];
    if ((state == CLEAR) && (ptr == bus.raddr_a)) next_a = '0;
    if (wr_ok && (bus.waddr == bus.raddr_a))      next_a = bus.wdata;
    if (!in_range(bus.raddr_a))                   next_a = '0;

    next_b = regs[bus.raddr_b];
    if ((state == CLEAR) && (ptr == bus.raddr_b)) next_b = '0;
    if (wr_ok && (bus.waddr == bus.raddr_b))      next_b = bus.wdata;
    if (!in_range(bus.raddr_b))                   next_b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      bus.rdata_a <= '0;
      bus.rdata_b <= '0;
      bus.wr_err  <= 1'b0;
    end else begin
      if (wr_ok)           regs[bus.waddr] <= bus.wdata;
      if (state == CLEAR)  regs[ptr]       <= '0;
      bus.rdata_a <= next_a;
      bus.rdata_b <= next_b;
      bus.wr_err  <= bus.we && !wr_ok;
    end
  end

  always_comb begin
    bus.regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) bus.regs_flat[i*WIDTH +: WIDTH] = regs[i];
  end

endmodule
